two_bit_full_adder: RTL and testbench
=====================================

Name: two_bit_full_adder

Overview:
- 2-bit unsigned ripple-carry adder built from two 1-bit full-adder stages.
- Operands arrive as discrete bit ports: A = {a_1,a_0}, B = {b_1,b_0}.
- Produces 3-bit result {cout,s_1,s_0} = A + B.
- Leaf arithmetic block; the sum is registered on the system clock, with asynchronous active-low reset.

Parameters:
- OUT_REG, default 1: 1 = outputs registered (one-cycle latency); 0 = outputs purely combinational, clk/rst_n ignored.

Ports:
- clk    input   1  system clock, rising-edge active
- rst_n  input   1  asynchronous active-low reset
- a_0    input   1  operand A bit 0 (LSB)
- b_0    input   1  operand B bit 0 (LSB)
- a_1    input   1  operand A bit 1 (MSB)
- b_1    input   1  operand B bit 1 (MSB)
- s_0    output  1  sum bit 0
- s_1    output  1  sum bit 1
- cout   output  1  carry out of bit 1 (sum bit 2)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Stage 0 is a full adder with carry-in tied to 0:
  - s0_c = a_0 ^ b_0
  - c0 = a_0 & b_0
- Stage 1 is a full adder taking c0 as carry-in:
  - s1_c = a_1 ^ b_1 ^ c0
  - c1 = (a_1 & b_1) | (c0 & (a_1 ^ b_1))
- Arithmetic:
  - Unsigned; result range 0..6.
  - No overflow is possible; cout is the MSB of the 3-bit result.
- OUT_REG=1:
  - On each clk rising edge, {cout,s_1,s_0} <= {c1,s1_c,s0_c}.
  - Latency is exactly 1 cycle.
  - The outputs hold their value between edges.
- OUT_REG=0:
  - {cout,s_1,s_0} = {c1,s1_c,s0_c} combinationally, with zero latency.
- Reset:
  - rst_n low forces s_0=0, s_1=0, cout=0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while rst_n is low, regardless of inputs.
  - Reset is asserted and released asynchronously.
  - After release, the first rising edge with rst_n high loads the current sum.
  - Reset asserted mid-operation discards the pending result; no state survives.
- No handshake:
  - A new operand pair is accepted every cycle.
  - Back-to-back changes are fully pipelined: the output at edge N+1 reflects the inputs sampled at edge N.
- Inputs change at most once per clock period and must be stable around the rising edge.
- No internal state besides the three output flops.

Test Plan:
- Reset: hold rst_n=0 with a_0=a_1=b_0=b_1=1 -> s_0=s_1=cout=0 throughout; after release, first edge gives {cout,s_1,s_0}=110 (3+3=6).
- Exhaustive sweep of all 16 combinations of (a_0,b_0,a_1,b_1), one per cycle -> each output equals A+B one cycle later.
  - Example: A=0, B=0 -> 000.
  - Example: A=2, B=1 -> 011.
- Carry propagation: a_0=1, b_0=1, a_1=0, b_1=0 -> s_0=0, s_1=1, cout=0 (1+1=2).
- Carry through MSB: a_0=1, b_0=1, a_1=1, b_1=0 -> s_0=0, s_1=0, cout=1 (3+1=4).
- Mid-stream reset: apply A=3, B=2, then pulse rst_n low between edges -> outputs drop to 000 immediately; after release the next edge shows 101.
- OUT_REG=0 build: A=2, B=2 -> {cout,s_1,s_0}=100 in the same cycle, with clk idle.

Source files
------------

// File: rtl/two_bit_full_adder.sv
// two_bit_full_adder: 2-bit unsigned ripple-carry adder made of two 1-bit
// full-adder stages. The 3-bit result {cout,s_1,s_0} is either registered
// (one-cycle latency, async active-low reset) or purely combinational.
module two_bit_full_adder #(
    parameter int OUT_REG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_0,
    input  logic b_0,
    input  logic a_1,
    input  logic b_1,
    output logic s_0,
    output logic s_1,
    output logic cout
);

    // Operands gathered into vectors so the stages can be generated uniformly.
    logic [1:0] a_v;
    logic [1:0] b_v;
    logic [1:0] sum_c;
    logic [2:0] carry;

    assign a_v = {a_1, a_0};
    assign b_v = {b_1, b_0};

    // The LSB stage has no incoming carry.
    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stage
            // One full adder: sum is the parity of its three inputs, carry
            // is generated by a&b or propagated from carry-in when a^b.
            assign sum_c[gi]     = a_v[gi] ^ b_v[gi] ^ carry[gi];
            assign carry[gi + 1] = (a_v[gi] & b_v[gi])
                                 | (carry[gi] & (a_v[gi] ^ b_v[gi]));
        end
    endgenerate

    // Combinational 3-bit result; cout is the carry out of the MSB stage.
    logic [2:0] result_d;

    // Assemble the unregistered result word from the ripple chain.
    always_comb begin
        result_d = {carry[2], sum_c[1], sum_c[0]};
    end

    generate
        if (OUT_REG != 0) begin : g_registered
            logic [2:0] result_q;

            // Output register: cleared immediately on reset, otherwise
            // captures the new sum every rising edge (no enable, no handshake).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    result_q <= 3'b000;
                end else begin
                    result_q <= result_d;
                end
            end

            assign {cout, s_1, s_0} = result_q;
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign {cout, s_1, s_0} = result_d;
        end
    endgenerate

endmodule

// File: tb/tb_two_bit_full_adder.sv
// Testbench for two_bit_full_adder: registered and combinational builds side
// by side, checked against an arithmetic model (A+B) every cycle plus a set of
// hand-computed expectations.
module tb_two_bit_full_adder;

    logic clk;
    logic rst_n;
    logic a_0, b_0, a_1, b_1;
    logic s_0_r, s_1_r, cout_r;
    logic s_0_c, s_1_c, cout_c;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    two_bit_full_adder #(.OUT_REG(1)) dut_reg (
        .clk(clk), .rst_n(rst_n),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1),
        .s_0(s_0_r), .s_1(s_1_r), .cout(cout_r)
    );

    two_bit_full_adder #(.OUT_REG(0)) dut_comb (
        .clk(clk), .rst_n(rst_n),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1),
        .s_0(s_0_c), .s_1(s_1_c), .cout(cout_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain arithmetic view of the operands.
    function automatic logic [2:0] add_ab();
        logic [2:0] a3, b3;
        a3 = {1'b0, a_1, a_0};
        b3 = {1'b0, b_1, b_0};
        return a3 + b3;
    endfunction

    // Model: the registered output is the sum seen at the last edge taken
    // while out of reset, and zero whenever reset has been asserted since.
    logic [2:0] exp_reg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_reg <= 3'b000;
        else        exp_reg <= add_ab();
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("reg_model",  {cout_r, s_1_r, s_0_r}, exp_reg);
            chk("comb_model", {cout_c, s_1_c, s_0_c}, add_ab());
        end
    end

    task automatic drive(input logic [1:0] a, input logic [1:0] b);
        {a_1, a_0} = a;
        {b_1, b_0} = b;
    endtask

    // Present operands 2 time units after an edge; they are sampled at the next edge.
    task automatic apply(input logic [1:0] a, input logic [1:0] b);
        @(posedge clk);
        #2;
        drive(a, b);
    endtask

    // Look just after the next edge and compare with a literal.
    task automatic expect_next(input string name, input logic [2:0] req);
        @(posedge clk);
        #1;
        chk(name, {cout_r, s_1_r, s_0_r}, req);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'd3, 2'd3);

        // Reset held with all ones on the inputs: outputs stay zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", {cout_r, s_1_r, s_0_r}, 3'b000);
        end

        // Release between edges; the first edge loads 3+3=6.
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        expect_next("rst_release", 3'b110);
        cmp_en = 1'b1;

        // Exhaustive sweep, one combination per cycle.
        for (int i = 0; i < 16; i++) begin
            apply(i[3:2], i[1:0]);
            if (i == 0)  expect_next("sweep_0p0", 3'b000);
            if (i == 9)  expect_next("sweep_2p1", 3'b011);
        end

        // Carry from bit 0 into bit 1: 1+1=2.
        apply(2'd1, 2'd1);
        expect_next("carry_b1", 3'b010);

        // Carry through the MSB: 3+1=4.
        apply(2'd3, 2'd1);
        expect_next("carry_msb", 3'b100);

        // Mid-stream reset pulse between edges.
        apply(2'd3, 2'd2);
        @(posedge clk);
        #2;
        chk("mid_before", {cout_r, s_1_r, s_0_r}, 3'b101);
        rst_n = 1'b0;
        #1;
        chk("mid_drop", {cout_r, s_1_r, s_0_r}, 3'b000);
        #1;
        rst_n = 1'b1;
        expect_next("mid_after", 3'b101);

        // Combinational build responds with no clock edge in between.
        @(negedge clk);
        #1;
        drive(2'd2, 2'd2);
        #1;
        chk("comb_2p2", {cout_c, s_1_c, s_0_c}, 3'b100);

        // Random operands with occasional asynchronous reset pulses.
        for (int i = 0; i < 300; i++) begin
            apply(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 19) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk("rnd_rst", {cout_r, s_1_r, s_0_r}, 3'b000);
                #1;
                rst_n = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
